// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state and reset-cause encodings.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_BTN  = 2'd1,
    CAUSE_SW   = 2'd2,
    CAUSE_WDOG = 2'd3
  } cause_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// N-flop synchroniser; latency SYNC_STAGES edges, no backpressure.
// Synchronous reset forces every flop to 0, so an active-low input reads as asserted out of reset.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer with button/software/watchdog sources and last-cause record.
// All outputs registered; a request forces every domain into reset on the next edge, no backpressure.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 15,
  parameter int STAGE_GAP      = 4,
  parameter int WDOG_CYCLES    = 2**20
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rst_in_n,
  input  logic                  i_sw_rst,
  input  logic                  i_wdog_en,
  input  logic                  i_wdog_kick,
  output logic [NUM_STAGES-1:0] o_rst_out,
  output logic                  o_ready,
  output logic [1:0]            o_cause
);

  localparam int CNT_W  = max_int(1, $clog2(max_int(STRETCH_CYCLES, STAGE_GAP)));
  localparam int IDX_W  = max_int(1, $clog2(NUM_STAGES));
  localparam int WDOG_W = $clog2(WDOG_CYCLES);

  logic                  w_sync_q;
  logic                  w_btn;
  logic                  w_wdog_to;
  logic                  w_req;
  cause_t                w_req_cause;

  state_t                r_state,   w_state_nxt;
  logic [CNT_W-1:0]      r_cnt,     w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx,     w_idx_nxt;
  logic [WDOG_W-1:0]     r_wdog,    w_wdog_nxt;
  logic [NUM_STAGES-1:0] r_rst_out, w_rst_out_nxt;
  logic                  r_ready,   w_ready_nxt;
  cause_t                r_cause,   w_cause_nxt;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_rst_in_n),
    .o_q  (w_sync_q)
  );

  assign w_btn     = ~w_sync_q;
  // A kick in the terminal cycle wins over the timeout.
  assign w_wdog_to = (r_state == ST_RUN) && i_wdog_en && !i_wdog_kick &&
                     (r_wdog == WDOG_W'(WDOG_CYCLES - 1));
  assign w_req     = w_btn | i_sw_rst | w_wdog_to;

  always_comb begin
    w_req_cause = r_cause;
    if (i_sw_rst)  w_req_cause = CAUSE_SW;
    if (w_wdog_to) w_req_cause = CAUSE_WDOG;
    if (w_btn)     w_req_cause = CAUSE_BTN;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_wdog_nxt    = '0;
    w_rst_out_nxt = r_rst_out;
    w_ready_nxt   = r_ready;
    w_cause_nxt   = r_cause;

    if ((r_state != ST_ASSERT) && w_req) begin
      w_state_nxt   = ST_ASSERT;
      w_cnt_nxt     = '0;
      w_idx_nxt     = '0;
      w_rst_out_nxt = '1;
      w_ready_nxt   = 1'b0;
      w_cause_nxt   = w_req_cause;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          w_rst_out_nxt = '1;
          w_ready_nxt   = 1'b0;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
          if (i_sw_rst) w_cause_nxt = w_btn ? CAUSE_BTN : CAUSE_SW;
          if (!w_btn && !i_sw_rst) w_state_nxt = ST_STRETCH;
        end
        ST_STRETCH: begin
          if (r_cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
            w_cnt_nxt        = '0;
            w_rst_out_nxt[0] = 1'b0;
            if (NUM_STAGES == 1) begin
              w_state_nxt = ST_RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_RELEASE;
              w_idx_nxt   = IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
            w_cnt_nxt            = '0;
            w_rst_out_nxt[r_idx] = 1'b0;
            if (r_idx == IDX_W'(NUM_STAGES - 1)) begin
              w_state_nxt = ST_RUN;
              w_ready_nxt = 1'b1;
              w_idx_nxt   = '0;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (i_wdog_en && !i_wdog_kick) w_wdog_nxt = r_wdog + WDOG_W'(1);
        end
        default: begin
          w_state_nxt   = ST_ASSERT;
          w_rst_out_nxt = '1;
          w_ready_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wdog    <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_cause   <= CAUSE_POR;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_wdog    <= w_wdog_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_ready   <= w_ready_nxt;
      r_cause   <= w_cause_nxt;
    end
  end

  assign o_rst_out = r_rst_out;
  assign o_ready   = r_ready;
  assign o_cause   = r_cause;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: power-up vector table, directed reset-source sequences, randomized run vs reference model.
module tb_rst_seq;

  localparam int NS    = 3;
  localparam int SS    = 2;
  localparam int SC    = 15;
  localparam int SG    = 4;
  localparam int WD    = 100;
  localparam int T_RUN = SC + (NS - 1) * SG;

  logic          clk = 1'b0;
  logic          rst, rst_in_n, sw_rst, wdog_en, wdog_kick;
  logic [NS-1:0] rst_out;
  logic          ready;
  logic [1:0]    cause;

  int n_checks = 0;
  int n_fail   = 0;

  rst_seq #(
    .NUM_STAGES    (NS),
    .SYNC_STAGES   (SS),
    .STRETCH_CYCLES(SC),
    .STAGE_GAP     (SG),
    .WDOG_CYCLES   (WD)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rst_in_n (rst_in_n),
    .i_sw_rst   (sw_rst),
    .i_wdog_en  (wdog_en),
    .i_wdog_kick(wdog_kick),
    .o_rst_out  (rst_out),
    .o_ready    (ready),
    .o_cause    (cause)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects rst_out[0] to fall after exactly first_low more edges, then the 4-edge stage cadence.
  task automatic check_release(input string tag, input int first_low, input logic [1:0] exp_cause);
    repeat (first_low - 1) tick();
    check({tag, "_held"}, rst_out, 3'b111);
    tick();
    check({tag, "_s0"}, rst_out, 3'b110);
    repeat (3) tick();
    check({tag, "_s0_gap"}, rst_out, 3'b110);
    tick();
    check({tag, "_s1"}, rst_out, 3'b100);
    repeat (3) tick();
    check({tag, "_notready"}, ready, 1'b0);
    tick();
    check({tag, "_s2"}, rst_out, 3'b000);
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_cause"}, cause, exp_cause);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_ready_wait"}, ready, 1'b1);
  endtask

  // Reference model: tracks time since the sequence started instead of FSM states.
  logic          m_asserted;
  int            m_t;
  int            m_wd;
  logic [1:0]    m_cause;
  logic [SS-1:0] m_sync;

  task automatic model_step();
    logic btn, run, to;
    if (rst) begin
      m_asserted = 1'b1;
      m_t        = 0;
      m_wd       = 0;
      m_cause    = 2'd0;
      m_sync     = '0;
      return;
    end
    btn = !m_sync[SS-1];
    run = !m_asserted && (m_t >= T_RUN);
    to  = run && wdog_en && !wdog_kick && (m_wd == WD - 1);
    if (!m_asserted && (btn || sw_rst || to)) begin
      m_asserted = 1'b1;
      m_cause    = btn ? 2'd1 : (to ? 2'd3 : 2'd2);
      m_wd       = 0;
      m_t        = 0;
    end else if (m_asserted) begin
      if (sw_rst) m_cause = btn ? 2'd1 : 2'd2;
      if (!btn && !sw_rst) begin
        m_asserted = 1'b0;
        m_t        = 0;
      end
    end else begin
      m_wd = (run && wdog_en && !wdog_kick) ? m_wd + 1 : 0;
      if (m_t < T_RUN) m_t++;
    end
    m_sync = {m_sync[SS-2:0], rst_in_n};
  endtask

  function automatic logic [5:0] model_out();
    logic [NS-1:0] ro;
    for (int k = 0; k < NS; k++) ro[k] = m_asserted || (m_t < SC + k * SG);
    return {ro, !m_asserted && (m_t >= T_RUN), m_cause};
  endfunction

  typedef struct {
    int         edge_n;
    logic [2:0] ro;
    logic       rdy;
    logic [1:0] cs;
  } vec_t;

  vec_t tbl[8];
  int   hold;

  initial begin
    int   cur;
    logic tripped;

    tbl[0] = '{edge_n: 0,  ro: 3'b111, rdy: 1'b0, cs: 2'd0};
    tbl[1] = '{edge_n: 16, ro: 3'b111, rdy: 1'b0, cs: 2'd0};
    tbl[2] = '{edge_n: 17, ro: 3'b110, rdy: 1'b0, cs: 2'd0};
    tbl[3] = '{edge_n: 20, ro: 3'b110, rdy: 1'b0, cs: 2'd0};
    tbl[4] = '{edge_n: 21, ro: 3'b100, rdy: 1'b0, cs: 2'd0};
    tbl[5] = '{edge_n: 24, ro: 3'b100, rdy: 1'b0, cs: 2'd0};
    tbl[6] = '{edge_n: 25, ro: 3'b000, rdy: 1'b1, cs: 2'd0};
    tbl[7] = '{edge_n: 40, ro: 3'b000, rdy: 1'b1, cs: 2'd0};

    rst = 1'b1; rst_in_n = 1'b1; sw_rst = 1'b0; wdog_en = 1'b0; wdog_kick = 1'b0;
    tick(); tick();
    check("reset_rst_out", rst_out, 3'b111);
    check("reset_ready", ready, 1'b0);
    check("reset_cause", cause, 2'd0);

    // Power-up release timing; edge 0 is the first edge with rst low.
    rst = 1'b0;
    cur = -1;
    for (int i = 0; i < 8; i++) begin
      while (cur < tbl[i].edge_n) begin
        tick();
        cur++;
      end
      check($sformatf("pwr_e%0d", tbl[i].edge_n), {rst_out, ready, cause},
            {tbl[i].ro, tbl[i].rdy, tbl[i].cs});
    end

    // Button pressed for 5 cycles while running.
    rst_in_n = 1'b0;
    tick(); tick();
    check("btn_sync_delay", rst_out, 3'b000);
    tick();
    check("btn_assert", rst_out, 3'b111);
    check("btn_cause", cause, 2'd1);
    check("btn_ready_low", ready, 1'b0);
    tick(); tick();
    check("btn_held", rst_out, 3'b111);
    rst_in_n = 1'b1;
    check_release("btn_rel", 18, 2'd1);

    // Software reset from RUN.
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check("sw_assert", rst_out, 3'b111);
    check("sw_cause", cause, 2'd2);
    check_release("sw_rel", 16, 2'd2);

    // Software reset in the middle of the release sequence.
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    repeat (16) tick();
    check("swrel_pre", rst_out, 3'b110);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check("swrel_assert", rst_out, 3'b111);
    check_release("swrel_rel", 16, 2'd2);

    // Kicks every 50 cycles keep the watchdog quiet.
    wdog_en = 1'b1;
    tripped = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wdog_kick = (i % 50 == 49);
      tick();
      if (rst_out !== 3'b000) tripped = 1'b1;
    end
    wdog_kick = 1'b0;
    check("wdog_kick50", tripped, 1'b0);

    // Kick in the terminal cycle beats the timeout.
    wdog_en = 1'b0;
    tick();
    wdog_en = 1'b1;
    repeat (99) tick();
    wdog_kick = 1'b1;
    tick();
    wdog_kick = 1'b0;
    check("wdog_kick_last", {rst_out, ready}, 4'b0001);

    // Unkicked watchdog trips after exactly WD edges.
    repeat (99) tick();
    check("wdog_edge99", rst_out, 3'b000);
    tick();
    check("wdog_trip", rst_out, 3'b111);
    check("wdog_cause", cause, 2'd3);
    wdog_en = 1'b0;
    check_release("wdog_rel", 16, 2'd3);

    // Button and software request seen on the same edge: button wins.
    rst_in_n = 1'b0;
    tick(); tick();
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    rst_in_n = 1'b1;
    check("swbtn_assert", rst_out, 3'b111);
    check("swbtn_cause", cause, 2'd1);
    wait_ready("swbtn");

    // Synchronous rst mid-sequence.
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst", {rst_out, ready, cause}, {3'b111, 1'b0, 2'd0});
    wait_ready("midrst");
    check("midrst_cause", cause, 2'd0);

    // Randomized run against the reference model.
    hold = 0;
    wdog_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst = (i == 0) || ($urandom % 600 == 0);
      if (hold > 0) hold--;
      else if ($urandom % 90 == 0) hold = $urandom_range(1, 25);
      rst_in_n  = (hold == 0);
      sw_rst    = ($urandom % 150 == 0);
      if ($urandom % 200 == 0) wdog_en = ~wdog_en;
      wdog_kick = ($urandom % 70 == 0);
      model_step();
      tick();
      check($sformatf("rand_c%0d", i), {rst_out, ready, cause}, model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
